// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and BCD digit constants for the up-timer.
// Revision: 1.0
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam int         DIGIT_W   = 4;

endpackage

`default_nettype wire

// File: rtl/zero_to_nine_cell.sv
// zero_to_nine_cell: one BCD digit counting 0..9, wrapping 9->0 on inc.
// Revision: 1.0
`default_nettype none

module zero_to_nine_cell
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max
);

  assign at_max = (q == DIGIT_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= at_max ? '0 : q + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/zero_to_nine_up_timer.sv
// zero_to_nine_up_timer: NDIG-digit BCD elapsed-time counter with run-control FSM.
// Optional macro TIMER_AUTORELOAD_EN: a tick in DONE restarts counting from zero.
// Revision: 1.0
`default_nettype none

module zero_to_nine_up_timer
  import timer_pkg::*;
#(
  parameter int NDIG = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic [DIGIT_W*NDIG-1:0] target,
  output logic [DIGIT_W*NDIG-1:0] count,
  output logic                    running,
  output logic                    done,
  output logic                    carry
);

  state_t            state;
  state_t            state_nxt;
  logic              inc;
  logic              clr_cnt;
  logic              match;
  logic [NDIG-1:0]   at_max;
  logic [NDIG-1:0]   dig_inc;

  // Non-BCD target nibbles never equal a BCD count, so they simply never match.
  assign match   = (count == target);
  assign running = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    clr_cnt   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      clr_cnt   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) state_nxt = RUN;
        end
        RUN: begin
          if (stop)       state_nxt = PAUSE;
          else if (match) state_nxt = DONE;
          else if (tick)  inc       = 1'b1;
        end
        PAUSE: begin
          if (start && !stop) state_nxt = RUN;
        end
        DONE: begin
`ifdef TIMER_AUTORELOAD_EN
          if (stop) begin
            state_nxt = PAUSE;
          end else if (start || tick) begin
            state_nxt = RUN;
            clr_cnt   = 1'b1;
          end
`else
          if (start && !stop) begin
            state_nxt = RUN;
            clr_cnt   = 1'b1;
          end
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      carry <= 1'b0;
    end else begin
      state <= state_nxt;
      carry <= inc & (&at_max);
    end
  end

  generate
    for (genvar i = 0; i < NDIG; i++) begin : g_digit
      if (i == 0) begin : g_first
        assign dig_inc[i] = inc;
      end else begin : g_chain
        assign dig_inc[i] = dig_inc[i-1] & at_max[i-1];
      end

      zero_to_nine_cell u_cell (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_cnt),
        .inc    (dig_inc[i]),
        .q      (count[DIGIT_W*i +: DIGIT_W]),
        .at_max (at_max[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_zero_to_nine_up_timer.sv
// tb_zero_to_nine_up_timer: directed self-checking bench for the BCD up-timer.
// Revision: 1.0
`default_nettype none

module tb_zero_to_nine_up_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] target = 8'h00;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       carry;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zero_to_nine_up_timer #(.NDIG(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .target  (target),
    .count   (count),
    .running (running),
    .done    (done),
    .carry   (carry)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_cmp++;
    if ({count, running, done, carry} !== 11'h000) begin
      n_err++;
      $display("FAIL reset: got count=%h run=%b done=%b carry=%b expected 00/0/0/0",
               count, running, done, carry);
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_count_up();
    target = 8'h12;
    do_start();
    n_cmp++;
    if (running !== 1'b1 || count !== 8'h00) begin
      n_err++;
      $display("FAIL count_start: got run=%b count=%h expected 1/00", running, count);
    end
    for (int i = 1; i <= 12; i++) begin
      tick = 1'b1;
      cyc(1);
      n_cmp++;
      if (count !== bcd(i)) begin
        n_err++;
        $display("FAIL count_step%0d: got %h expected %h", i, count, bcd(i));
      end
    end
    tick = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_early: got %b expected 0", done);
    end
    cyc(1);
    n_cmp++;
    if (done !== 1'b1 || running !== 1'b0) begin
      n_err++;
      $display("FAIL done_latency: got done=%b run=%b expected 1/0", done, running);
    end
`ifndef TIMER_AUTORELOAD_EN
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    n_cmp++;
    if (count !== 8'h12 || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_hold: got count=%h done=%b expected 12/1", count, done);
    end
`endif
    do_clear();
    n_cmp++;
    if (count !== 8'h00 || running !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL clear_done: got count=%h run=%b done=%b expected 00/0/0",
               count, running, done);
    end
  endtask

  task automatic test_wrap();
    target = 8'hA0;
    do_start();
    tick = 1'b1;
    cyc(99);
    n_cmp++;
    if (count !== 8'h99 || carry !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_99: got count=%h carry=%b expected 99/0", count, carry);
    end
    cyc(1);
    tick = 1'b0;
    n_cmp++;
    if (count !== 8'h00 || carry !== 1'b1 || running !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_00: got count=%h carry=%b run=%b expected 00/1/1",
               count, carry, running);
    end
    cyc(1);
    n_cmp++;
    if (carry !== 1'b0 || running !== 1'b1) begin
      n_err++;
      $display("FAIL carry_pulse: got carry=%b run=%b expected 0/1", carry, running);
    end
    do_clear();
  endtask

  task automatic test_stop_resume();
    target = 8'h50;
    do_start();
    tick = 1'b1;
    cyc(5);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    n_cmp++;
    if (count !== 8'h05 || running !== 1'b0) begin
      n_err++;
      $display("FAIL stop_tick: got count=%h run=%b expected 05/0", count, running);
    end
    cyc(3);
    tick = 1'b0;
    n_cmp++;
    if (count !== 8'h05) begin
      n_err++;
      $display("FAIL pause_hold: got %h expected 05", count);
    end
    do_start();
    n_cmp++;
    if (running !== 1'b1 || count !== 8'h05) begin
      n_err++;
      $display("FAIL resume: got run=%b count=%h expected 1/05", running, count);
    end
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    n_cmp++;
    if (count !== 8'h06) begin
      n_err++;
      $display("FAIL resume_tick: got %h expected 06", count);
    end
    do_clear();
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    tick  = 1'b1;
    cyc(2);
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
    n_cmp++;
    if (running !== 1'b0 || done !== 1'b0 || count !== 8'h00) begin
      n_err++;
      $display("FAIL start_stop_idle: got run=%b done=%b count=%h expected 0/0/00",
               running, done, count);
    end
  endtask

  task automatic test_done_restart();
    target = 8'h03;
    do_start();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
    end
    cyc(1);
    n_cmp++;
    if (done !== 1'b1 || count !== 8'h03) begin
      n_err++;
      $display("FAIL done_03: got done=%b count=%h expected 1/03", done, count);
    end
    do_start();
    n_cmp++;
    if (count !== 8'h00 || running !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL done_restart: got count=%h run=%b done=%b expected 00/1/0",
               count, running, done);
    end
    do_clear();
  endtask

  task automatic test_target_zero();
    target = 8'h00;
    do_start();
    n_cmp++;
    if (running !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL tz_edge1: got run=%b done=%b expected 1/0", running, done);
    end
    cyc(1);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL tz_edge2: got done=%b expected 1", done);
    end
    do_clear();
  endtask

  task automatic test_rst_clear();
    target = 8'h50;
    do_start();
    tick = 1'b1;
    cyc(7);
    tick = 1'b0;
    n_cmp++;
    if (count !== 8'h07) begin
      n_err++;
      $display("FAIL pre_clear: got %h expected 07", count);
    end
    do_clear();
    n_cmp++;
    if (count !== 8'h00 || running !== 1'b0) begin
      n_err++;
      $display("FAIL clear_run: got count=%h run=%b expected 00/0", count, running);
    end
    do_start();
    tick = 1'b1;
    cyc(7);
    tick  = 1'b0;
    rst   = 1'b1;
    start = 1'b1;
    cyc(1);
    rst   = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (count !== 8'h00 || running !== 1'b0) begin
      n_err++;
      $display("FAIL rst_start: got count=%h run=%b expected 00/0", count, running);
    end
  endtask

`ifdef TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    target = 8'h02;
    do_start();
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
    end
    cyc(1);
    for (int r = 0; r < 2; r++) begin
      n_cmp++;
      if (done !== 1'b1 || count !== 8'h02) begin
        n_err++;
        $display("FAIL ar_done%0d: got done=%b count=%h expected 1/02", r, done, count);
      end
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      n_cmp++;
      if (count !== 8'h00 || running !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL ar_reload%0d: got count=%h run=%b done=%b expected 00/1/0",
                 r, count, running, done);
      end
      for (int i = 0; i < 2; i++) begin
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
      end
      cyc(1);
    end
    do_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_stop_resume();
    test_start_stop_idle();
    test_done_restart();
    test_target_zero();
    test_rst_clear();
`ifdef TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
